eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter that shares the single RMII TX dibit
//  stream (axiov/axiod) between two frame producers. Examples are the
//  lightboard image sender and the control/ack sender.
//  Grants one requester per frame, passes its dibits through with one cycle of
//  registered latency, then enforces the Ethernet inter-frame gap.
//  Also runs a max-length watchdog. Sits between the frame builders and the
//  CRC/preamble stage ahead of the PHY.
// PARAMETERS
//  IFG_DIBITS     48    idle cycles forced after every frame (96 bit times)
//  MAX_DIBITS     6104  watchdog: max dibits per frame (1526 B * 4)
//  START_TIMEOUT  64    cycles a granted requester has to raise axiiv
// PORTS
//  clk       in   1  50 MHz RMII reference clock
//  rst_n     in   1  asynchronous, active-low reset
//  req       in   2  req[i]=1: requester i has a frame ready
//  grant     out  2  one-hot; grant[i]=1: requester i owns the stream
//  axiiv0    in   1  requester 0 dibit valid
//  axiid0    in   2  requester 0 dibit
//  axiiv1    in   1  requester 1 dibit valid
//  axiid1    in   2  requester 1 dibit
//  axiov     out  1  muxed dibit valid to the downstream stage
//  axiod     out  2  muxed dibit
//  busy      out  1  high in every state except IDLE
//  abort     out  1  one-cycle pulse on watchdog or start timeout
// BEHAVIOUR
//  - Clock and reset: single clock. rst_n is asynchronous and active-low.
//  - Reset values: grant=0, axiov=0, axiod=0, busy=0, abort=0.
//    State=IDLE, rr_last=1 (so requester 0 wins first), all counters 0.
//  - All outputs are registered. axiov/axiod follow the granted input one
//    cycle later.
//  - State IDLE:
//    - If req!=0: pick i. With a single requester, take it. With both, take
//      the requester != rr_last.
//    - Next cycle: grant[i]=1, go GRANT, start counter=0.
//  - State GRANT:
//    - axiiv_i=1: go STREAM; that dibit is forwarded; len=1.
//    - Else if req[i]=0: grant=0, go IDLE (no gap, rr_last unchanged).
//    - Else if start counter reaches START_TIMEOUT-1: abort pulse, grant=0,
//      rr_last=i, go IDLE.
//  - State STREAM:
//    - axiov<=axiiv_i, axiod<=axiid_i. len increments on each valid dibit.
//    - The first cycle with axiiv_i=0 ends the frame: grant=0, rr_last=i, go
//      GAP.
//    - The grant is held until frame end even if req[i] drops mid-frame.
//  - Watchdog: when len==MAX_DIBITS and axiiv_i is still 1:
//    - Force axiov=0, abort pulse, grant=0, rr_last=i, go GAP.
//    - Remaining input dibits are ignored.
//  - State GAP:
//    - Count IFG_DIBITS cycles with axiov=0, then go IDLE.
//    - Requests arriving during GAP wait; none is lost, since req is level.
//  - Non-granted inputs are ignored entirely; their axiiv has no effect.
//  - grant never has more than one bit set.
//  - Gap guarantee: at least IFG_DIBITS idle cycles between the last axiov=1
//    of one frame and the first of the next.
//  - Width rules: len is wide enough for MAX_DIBITS (13 bits at default). The
//    gap and start counters saturate at their limits.
//  - Reset mid-frame: outputs drop to 0 asynchronously; the FSM restarts in
//    IDLE with rr_last=1.
// TESTING
//  1. req=01, requester 0 sends 8 dibits 0,1,2,3,0,1,2,3 ->
//     - grant=01 one cycle after req.
//     - axiov high for exactly 8 cycles with the same sequence, 1-cycle lag.
//     - grant=00 after the frame, then 48 idle cycles.
//  2. req=11 from reset, each sends 4 dibits ->
//     - Order is r0 frame, 48-cycle gap, r1 frame, 48-cycle gap.
//     - r1 never appears on axiod while grant=01.
//  3. r0 requests continuously, r1 requests once ->
//     - Service alternates r0, r1, r0.
//     - r0 is never served twice in a row while r1 is pending.
//  4. r0 is granted but holds axiiv=0 ->
//     - abort pulses once after 64 cycles; grant=00.
//     - r1 (if requesting) is granted next.
//  5. r1 streams 6200 valid dibits ->
//     - axiov is high for exactly 6104 cycles, then abort pulses once.
//     - The gap follows; the later input is dropped.
//  6. rst_n pulled low at dibit 20 of a frame ->
//     - axiov=0 and grant=00 immediately.
//     - After release with req=11, requester 0 is granted first.

Source files
------------

// File: rtl/eth_tx_arbiter_if.sv
// Bundle between the two frame producers and the TX arbiter: requests, grants,
// the two producer dibit streams and the merged stream toward the CRC stage.
`timescale 1ns/1ps
interface eth_tx_arbiter_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic       axiiv0;
    logic [1:0] axiid0;
    logic       axiiv1;
    logic [1:0] axiid1;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       abort;

    modport master (
        output req, axiiv0, axiid0, axiiv1, axiid1,
        input  grant, axiov, axiod, busy, abort
    );

    modport slave (
        input  req, axiiv0, axiid0, axiiv1, axiid1,
        output grant, axiov, axiod, busy, abort
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one RMII TX dibit stream between
// two producers, with inter-frame gap, start timeout and max-length watchdog.
`timescale 1ns/1ps
module eth_tx_arbiter #(
    parameter int IFG_DIBITS    = 48,
    parameter int MAX_DIBITS    = 6104,
    parameter int START_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    eth_tx_arbiter_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_DIBITS + 1);
    localparam int GAP_W = (IFG_DIBITS > 1) ? $clog2(IFG_DIBITS) : 1;
    localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_DIBITS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_DIBITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_STREAM,
        S_GAP
    } state_t;

    state_t           r_state;
    logic             r_sel;
    logic             r_rr_last;
    logic [1:0]       r_grant;
    logic             r_axiov;
    logic [1:0]       r_axiod;
    logic             r_busy;
    logic             r_abort;
    logic [LEN_W-1:0] r_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TMO_W-1:0] r_start_cnt;

    logic             w_v;
    logic [1:0]       w_d;
    logic             w_req_sel;
    logic             w_pick;

    assign w_v       = r_sel ? bus.axiiv1 : bus.axiiv0;
    assign w_d       = r_sel ? bus.axiid1 : bus.axiid0;
    assign w_req_sel = bus.req[r_sel];
    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign w_pick    = (bus.req == 2'b11) ? ~r_rr_last : bus.req[1];

    // NOTE: every state register uses <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_rr_last   <= 1'b1;
            r_grant     <= 2'b00;
            r_axiov     <= 1'b0;
            r_axiod     <= 2'b00;
            r_busy      <= 1'b0;
            r_abort     <= 1'b0;
            r_len       <= '0;
            r_gap_cnt   <= '0;
            r_start_cnt <= '0;
        end else begin
            // NOTE: pulse and stream outputs default low each cycle; branches override.
            r_abort <= 1'b0;
            r_axiov <= 1'b0;
            r_axiod <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_sel       <= w_pick;
                        r_grant     <= w_pick ? 2'b10 : 2'b01;
                        r_start_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_v) begin
                        r_axiov <= 1'b1;
                        r_axiod <= w_d;
                        r_len   <= LEN_W'(1);
                        r_state <= S_STREAM;
                    end else if (!w_req_sel) begin
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_start_cnt == TMO_LAST) begin
                        r_abort   <= 1'b1;
                        r_grant   <= 2'b00;
                        r_rr_last <= r_sel;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_start_cnt <= r_start_cnt + TMO_W'(1);
                    end
                end
                S_STREAM: begin
                    if (w_v && (r_len == LEN_MAX)) begin
                        r_abort   <= 1'b1;
                        r_grant   <= 2'b00;
                        r_rr_last <= r_sel;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else if (w_v) begin
                        r_axiov <= 1'b1;
                        r_axiod <= w_d;
                        r_len   <= r_len + LEN_W'(1);
                    end else begin
                        r_grant   <= 2'b00;
                        r_rr_last <= r_sel;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.axiov = r_axiov;
    assign bus.axiod = r_axiod;
    assign bus.busy  = r_busy;
    assign bus.abort = r_abort;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: arbitration vector table, directed
// corner sequences and randomized frame mixes against a frame-level model.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    localparam int IFG  = 48;
    localparam int MAXD = 6104;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_arbiter_if bus ();

    eth_tx_arbiter #(
        .IFG_DIBITS   (IFG),
        .MAX_DIBITS   (MAXD),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Producer storage: per-requester dibit memory and frame length list.
    logic [1:0] pmem [2][8192];
    int         flen [2][64];
    int         fwr [2];
    int         frd [2];
    int         pwp [2];
    int         prd [2];
    int         fpos [2];
    bit         sending [2];
    bit         stall [2];
    bit         auto_drive = 1'b0;

    // Monitor state.
    logic [2:0] out_q [$];
    logic [2:0] exp_q [$];
    int         act_frames [$];
    int         exp_frames [$];
    int abort_cnt, abort_at_end, gap_cycles, g0_cycles;
    int min_gap, idle_run, cur_run, max_run, onehot_err, leak_err;
    bit seen_frame, prev_axiov;

    typedef struct packed {
        logic [1:0] pre;
        logic [1:0] req;
        logic [1:0] exp_grant;
        logic       exp_busy;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req    = 2'b00;
        bus.axiiv0 = 1'b0;
        bus.axiid0 = 2'b00;
        bus.axiiv1 = 1'b0;
        bus.axiid1 = 2'b00;
    endtask

    task automatic clear_prod();
        for (int i = 0; i < 2; i++) begin
            fwr[i] = 0; frd[i] = 0; pwp[i] = 0; prd[i] = 0; fpos[i] = 0;
            sending[i] = 1'b0; stall[i] = 1'b0;
        end
    endtask

    task automatic clear_mon();
        out_q.delete(); act_frames.delete();
        abort_cnt = 0; abort_at_end = 0; gap_cycles = 0; g0_cycles = 0;
        min_gap = 1000000; idle_run = 0; cur_run = 0; max_run = 0;
        onehot_err = 0; leak_err = 0; seen_frame = 1'b0; prev_axiov = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        auto_drive = 1'b0;
        clear_inputs();
        clear_prod();
        clear_mon();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_frame(input int i, input int len, input bit rnd);
        flen[i][fwr[i]] = len;
        fwr[i]++;
        for (int k = 0; k < len; k++) begin
            pmem[i][pwp[i]] = rnd ? 2'($urandom_range(0, 3)) : 2'(k % 4);
            pwp[i]++;
        end
    endtask

    // Frame-level reference: round-robin over the queued frames, each frame
    // truncated to the watchdog limit, every dibit tagged with its owner.
    function automatic void build_expected();
        int fi [2];
        int dp [2];
        int last;
        int w;
        int n;
        logic [2:0] e;
        exp_q.delete();
        exp_frames.delete();
        fi[0] = 0; fi[1] = 0; dp[0] = 0; dp[1] = 0;
        last = 1;
        while (fi[0] < fwr[0] || fi[1] < fwr[1]) begin
            if (fi[0] < fwr[0] && fi[1] < fwr[1]) w = 1 - last;
            else w = (fi[1] < fwr[1]) ? 1 : 0;
            n = (flen[w][fi[w]] < MAXD) ? flen[w][fi[w]] : MAXD;
            for (int k = 0; k < n; k++) begin
                e = {1'(w), pmem[w][dp[w] + k]};
                exp_q.push_back(e);
            end
            dp[w] += flen[w][fi[w]];
            fi[w]++;
            exp_frames.push_back(w);
            last = w;
        end
    endfunction

    // One clock: sample outputs at the falling edge, then drive producers.
    task automatic tick();
        logic       v;
        logic [1:0] d;
        logic       rq;
        @(negedge clk);
        if (bus.grant == 2'b11) onehot_err++;
        if (bus.grant == 2'b01) g0_cycles++;
        if (bus.abort) begin
            abort_cnt++;
            if (prev_axiov && !bus.axiov) abort_at_end++;
        end
        if (bus.busy && bus.grant == 2'b00) gap_cycles++;
        if (bus.axiov) begin
            if (bus.grant == 2'b00) leak_err++;
            if (!prev_axiov) begin
                if (seen_frame && idle_run < min_gap) min_gap = idle_run;
                act_frames.push_back(int'(bus.grant[1]));
            end
            out_q.push_back({bus.grant[1], bus.axiod});
            idle_run = 0;
            seen_frame = 1'b1;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            idle_run++;
            cur_run = 0;
        end
        prev_axiov = bus.axiov;
        if (auto_drive) begin
            for (int i = 0; i < 2; i++) begin
                v = 1'b0;
                d = 2'b00;
                if (sending[i]) begin
                    if (fpos[i] < flen[i][frd[i]]) begin
                        v = 1'b1; d = pmem[i][prd[i]]; prd[i]++; fpos[i]++;
                    end else begin
                        sending[i] = 1'b0; frd[i]++;
                    end
                end else if (bus.grant[i] && frd[i] < fwr[i] && !stall[i]) begin
                    sending[i] = 1'b1; v = 1'b1; d = pmem[i][prd[i]]; prd[i]++; fpos[i] = 1;
                end
                rq = sending[i] ? ((fwr[i] - frd[i]) > 1) : (frd[i] < fwr[i]);
                bus.req[i] = rq;
                if (i == 0) begin bus.axiiv0 = v; bus.axiid0 = d; end
                else        begin bus.axiiv1 = v; bus.axiid1 = d; end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        tick();
        while (!(frd[0] == fwr[0] && frd[1] == fwr[1] && !sending[0] && !sending[1] && !bus.busy)
               && n < budget) begin
            tick();
            n++;
        end
        check({name, "_completed"}, int'(n < budget), 1);
    endtask

    task automatic compare_stream(input string name);
        int ferr;
        int derr;
        ferr = 0;
        derr = 0;
        check({name, "_frames"}, act_frames.size(), exp_frames.size());
        for (int k = 0; k < act_frames.size() && k < exp_frames.size(); k++)
            if (act_frames[k] != exp_frames[k]) ferr++;
        check({name, "_order_err"}, ferr, 0);
        check({name, "_dibits"}, out_q.size(), exp_q.size());
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
            if (out_q[k] !== exp_q[k]) derr++;
        check({name, "_data_err"}, derr, 0);
        check({name, "_onehot_leak"}, onehot_err + leak_err, 0);
    endtask

    task automatic check_gap(input string name);
        check({name, "_min_gap"}, (min_gap >= IFG) ? IFG : min_gap, IFG);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{pre: 2'b00, req: 2'b00, exp_grant: 2'b00, exp_busy: 1'b0};
        vecs[1] = '{pre: 2'b00, req: 2'b01, exp_grant: 2'b01, exp_busy: 1'b1};
        vecs[2] = '{pre: 2'b00, req: 2'b10, exp_grant: 2'b10, exp_busy: 1'b1};
        vecs[3] = '{pre: 2'b00, req: 2'b11, exp_grant: 2'b01, exp_busy: 1'b1};
        vecs[4] = '{pre: 2'b01, req: 2'b11, exp_grant: 2'b10, exp_busy: 1'b1};
        vecs[5] = '{pre: 2'b10, req: 2'b11, exp_grant: 2'b01, exp_busy: 1'b1};
        vecs[6] = '{pre: 2'b01, req: 2'b01, exp_grant: 2'b01, exp_busy: 1'b1};
        vecs[7] = '{pre: 2'b10, req: 2'b10, exp_grant: 2'b10, exp_busy: 1'b1};

        clear_inputs();
        clear_prod();
        clear_mon();
        repeat (2) @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_axiov", int'(bus.axiov), 0);
        check("rst_axiod", int'(bus.axiod), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_abort", int'(bus.abort), 0);
        rst_n = 1'b1;

        // Arbitration decision table.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            if (vecs[t].pre != 2'b00) begin
                add_frame(vecs[t].pre[1] ? 1 : 0, 3, 1'b0);
                auto_drive = 1'b1;
                wait_idle($sformatf("vec%0d_pre", t), 300);
                auto_drive = 1'b0;
            end
            bus.req = vecs[t].req;
            tick();
            check($sformatf("vec%0d_grant", t), int'(bus.grant), int'(vecs[t].exp_grant));
            check($sformatf("vec%0d_busy", t), int'(bus.busy), int'(vecs[t].exp_busy));
            bus.req = 2'b00;
            repeat (3) tick();
        end

        // Single 8-dibit frame from requester 0.
        do_reset();
        add_frame(0, 8, 1'b0);
        build_expected();
        auto_drive = 1'b1;
        tick();
        check("t1_grant_before", int'(bus.grant), 0);
        tick();
        check("t1_grant_after_req", int'(bus.grant), 1);
        wait_idle("t1", 300);
        compare_stream("t1");
        check("t1_run_len", max_run, 8);
        check("t1_gap_cycles", gap_cycles, IFG);
        check("t1_abort", abort_cnt, 0);

        // Both request from reset, 4 dibits each.
        do_reset();
        add_frame(0, 4, 1'b1);
        add_frame(1, 4, 1'b1);
        build_expected();
        auto_drive = 1'b1;
        wait_idle("t2", 500);
        compare_stream("t2");
        check_gap("t2");
        check("t2_gap_cycles", gap_cycles, 2 * IFG);

        // r0 keeps requesting, r1 requests once.
        do_reset();
        add_frame(0, 4, 1'b1);
        add_frame(0, 5, 1'b1);
        add_frame(0, 6, 1'b1);
        add_frame(1, 7, 1'b1);
        build_expected();
        auto_drive = 1'b1;
        wait_idle("t3", 800);
        compare_stream("t3");
        check_gap("t3");

        // Granted r0 never starts; timeout hands the stream to r1.
        do_reset();
        stall[0] = 1'b1;
        add_frame(0, 4, 1'b1);
        add_frame(1, 5, 1'b1);
        auto_drive = 1'b1;
        n = 0;
        while (abort_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        check("t4_abort_seen", abort_cnt, 1);
        check("t4_grant_cycles", g0_cycles, TMO);
        check("t4_grant_cleared", int'(bus.grant), 0);
        frd[0] = fwr[0];
        stall[0] = 1'b0;
        wait_idle("t4", 500);
        check("t4_abort_total", abort_cnt, 1);
        check("t4_frames", act_frames.size(), 1);
        if (act_frames.size() > 0) check("t4_next_owner", act_frames[0], 1);
        check("t4_g0_total", g0_cycles, TMO);

        // Overlong frame from r1 trips the watchdog.
        do_reset();
        add_frame(1, 6200, 1'b1);
        build_expected();
        auto_drive = 1'b1;
        wait_idle("t5", 7000);
        check("t5_run_len", max_run, MAXD);
        check("t5_abort", abort_cnt, 1);
        check("t5_abort_at_end", abort_at_end, 1);
        check("t5_gap_cycles", gap_cycles, IFG);
        compare_stream("t5");

        // Reset in the middle of r1's frame.
        do_reset();
        add_frame(0, 4, 1'b1);
        add_frame(1, 40, 1'b0);
        auto_drive = 1'b1;
        n = 0;
        while (out_q.size() < 24 && n < 500) begin
            tick();
            n++;
        end
        check("t6_reached_dibit20", out_q.size(), 24);
        check("t6_pre_axiov", int'(bus.axiov), 1);
        rst_n = 1'b0;
        #1;
        check("t6_axiov_async", int'(bus.axiov), 0);
        check("t6_grant_async", int'(bus.grant), 0);
        check("t6_busy_async", int'(bus.busy), 0);
        auto_drive = 1'b0;
        clear_inputs();
        clear_prod();
        clear_mon();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 2'b11;
        tick();
        check("t6_grant_after_reset", int'(bus.grant), 1);

        // Randomized frame mixes.
        for (int r = 0; r < 4; r++) begin
            int nf;
            do_reset();
            for (int i = 0; i < 2; i++) begin
                nf = $urandom_range(1, 8);
                for (int f = 0; f < nf; f++) add_frame(i, $urandom_range(1, 30), 1'b1);
            end
            build_expected();
            auto_drive = 1'b1;
            wait_idle($sformatf("rand%0d", r), 5000);
            compare_stream($sformatf("rand%0d", r));
            check_gap($sformatf("rand%0d", r));
            check($sformatf("rand%0d_gap_cycles", r), gap_cycles, IFG * exp_frames.size());
            check($sformatf("rand%0d_abort", r), abort_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
